mem_access_stall: RTL and testbench
===================================

MEM_ACCESS_STALL -- requirements
Module: mem_access_stall

Interface
REQ-001 The block SHALL have the parameter TIMEOUT, default 255, meaning the maximum number of WAIT-state cycles before an access is aborted (range 1..255).
REQ-002 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have the port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have the port mem_valid, input, 1 bit: the ex_mem register holds a real (non-bubble) instruction.
REQ-005 The block SHALL have the ports mem_is_load and mem_is_store, input, 1 bit each: the instruction accesses memory; both high is treated as a store.
REQ-006 The block SHALL have the ports mem_addr (input, 64), mem_wdata (input, 64) and mem_size (input, 2): access address, store data, and size where 0=byte, 1=half, 2=word, 3=dword.
REQ-007 The block SHALL have the port mem_unsigned, input, 1 bit: a load is zero-extended when high, sign-extended when low.
REQ-008 The block SHALL have the port wb_wr_en, input, 1 bit: the mem_wb register captures this cycle (the MEM instruction advances).
REQ-009 The block SHALL have the ports bus_req (output, 1), bus_we (output, 1), bus_addr (output, 64), bus_wdata (output, 64) and bus_size (output, 2): the request channel.
REQ-010 The block SHALL have the ports bus_gnt (input, 1), bus_rvalid (input, 1), bus_rdata (input, 64) and bus_err (input, 1): grant, response valid, response data, and response error.
REQ-011 The block SHALL have the port mem_stall, output, 1 bit: the stall request to the pipeline traffic controller.
REQ-012 The block SHALL have the ports mem_rdata (output, 64) and mem_fault (output, 1): the extended load result and the access fault flag, both registered.

Function
REQ-013 The block SHALL implement the FSM states IDLE, REQ, WAIT and DONE.
REQ-014 An access SHALL be defined as acc = mem_valid & (mem_is_load | mem_is_store).
REQ-015 A misaligned access (addr[0] set for half; addr[1:0] nonzero for word; addr[2:0] nonzero for dword) SHALL be defined as mis.
REQ-016 In IDLE, the FSM SHALL go to DONE with mem_fault=1 if acc & mis, with no bus request issued.
REQ-017 In IDLE, the FSM SHALL go to REQ if acc & !mis, latching addr, wdata, size, we, and unsigned.
REQ-018 In IDLE, the FSM SHALL stay in IDLE otherwise.
REQ-019 In REQ, bus_req SHALL be 1, with bus_addr, bus_we, bus_wdata and bus_size driven from the latched values and held stable until bus_gnt.
REQ-020 In REQ, bus_gnt=1 SHALL cause a transition to WAIT; bus_req SHALL deassert in WAIT.
REQ-021 In WAIT, an 8-bit timeout counter SHALL start at 0 and increment each cycle.
REQ-022 In WAIT, bus_rvalid=1 SHALL cause a transition to DONE, capturing mem_fault=bus_err and, for loads, mem_rdata = the extended bus_rdata.
REQ-023 In WAIT, if the counter reaches TIMEOUT with bus_rvalid=0, the FSM SHALL go to DONE with mem_fault=1 and mem_rdata=0.
REQ-024 A bus_rvalid arriving in the same cycle as the timeout SHALL win: it is accepted and is not a fault.
REQ-025 In DONE, the FSM SHALL go to IDLE if wb_wr_en=1; otherwise it SHALL hold DONE with mem_rdata and mem_fault stable.
REQ-026 Load extension SHALL take bus_rdata bits [7:0], [15:0], [31:0] or [63:0] by latched size, then sign- or zero-extend to 64 bits; stores SHALL produce mem_rdata=0.
REQ-027 mem_stall SHALL be combinational: 1 when (IDLE & acc), REQ, or WAIT; 0 in DONE and in IDLE without acc.
REQ-028 Minimum latency SHALL be: request cycle t, gnt at t+1, rvalid at t+2 gives DONE at t+3, i.e. mem_stall high for 3 cycles.
REQ-029 A bus_rvalid or bus_gnt received outside its expected state SHALL be ignored.
REQ-030 mem_valid dropping while in REQ or WAIT SHALL NOT abort the access; the bus transaction always completes.

Reset
REQ-031 While reset is high, the FSM SHALL be in IDLE and the counter 0.
REQ-032 While reset is high, the outputs SHALL be bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, bus_size=0, mem_rdata=0 and mem_fault=0.
REQ-033 While reset is high, mem_stall SHALL be 0 regardless of inputs.
REQ-034 Reset asserted mid-access SHALL drop bus_req immediately (asynchronously), and any in-flight response after release SHALL be ignored.

Verification
REQ-035 Scenario load, mem_size=0, mem_unsigned=0, addr 0x1000, bus_rdata=0x80, gnt next cycle, rvalid one cycle after -> mem_stall high 3 cycles, mem_rdata=0xFFFFFFFFFFFFFF80, mem_fault=0.
REQ-036 Scenario store at addr 0x2008, size 3, wdata 0xDEADBEEF, gnt delayed 4 cycles -> bus_req held 5 cycles with bus_we=1 and stable addr/data; mem_rdata=0 at DONE.
REQ-037 Scenario load, size 2, addr 0x1002 -> no bus_req, mem_stall high 1 cycle, mem_fault=1 in DONE.
REQ-038 Scenario TIMEOUT=4, no rvalid -> DONE after 4 WAIT cycles with mem_fault=1; rvalid in the 4th cycle -> fault=0 and data captured.
REQ-039 Scenario DONE with wb_wr_en=0 for 3 cycles -> state, mem_rdata and mem_fault held and mem_stall=0; wb_wr_en=1 -> IDLE next cycle.
REQ-040 Scenario reset pulse during WAIT -> bus_req=0 and mem_stall=0 immediately; a stale rvalid after release -> ignored, state IDLE.

Source files
------------

// File: rtl/mem_access_stall.sv
// MEM-stage data bus access sequencer with pipeline stall.
// Aligns, issues and times out one bus access per instruction.
module mem_access_stall #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic        mem_is_load,
  input  logic        mem_is_store,
  input  logic [63:0] mem_addr,
  input  logic [63:0] mem_wdata,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  input  logic        wb_wr_en,
  output logic        bus_req,
  output logic        bus_we,
  output logic [63:0] bus_addr,
  output logic [63:0] bus_wdata,
  output logic [1:0]  bus_size,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [63:0] bus_rdata,
  input  logic        bus_err,
  output logic        mem_stall,
  output logic [63:0] mem_rdata,
  output logic        mem_fault
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  logic [7:0]  cnt;
  logic        uns_q;
  logic        acc;
  logic        mis;
  logic [63:0] ext;

  assign acc = mem_valid & (mem_is_load | mem_is_store);

  always_comb begin
    mis = 1'b0;
    unique case (mem_size)
      2'd0: mis = 1'b0;
      2'd1: mis = mem_addr[0];
      2'd2: mis = |mem_addr[1:0];
      2'd3: mis = |mem_addr[2:0];
    endcase
  end

  // Size and signedness come from the latched request, not the live inputs.
  always_comb begin
    ext = '0;
    unique case (bus_size)
      2'd0: ext = {{56{~uns_q & bus_rdata[7]}},
                   bus_rdata[7:0]};
      2'd1: ext = {{48{~uns_q & bus_rdata[15]}},
                   bus_rdata[15:0]};
      2'd2: ext = {{32{~uns_q & bus_rdata[31]}},
                   bus_rdata[31:0]};
      2'd3: ext = bus_rdata;
    endcase
    if (bus_we) ext = '0;
  end

  assign mem_stall = ~reset &
                     ((state == IDLE && acc) ||
                      state == REQ ||
                      state == WAIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      uns_q     <= 1'b0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_size  <= '0;
      mem_rdata <= '0;
      mem_fault <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (acc && mis) begin
            state     <= DONE;
            mem_fault <= 1'b1;
            mem_rdata <= '0;
          end else if (acc) begin
            state     <= REQ;
            bus_req   <= 1'b1;
            bus_we    <= mem_is_store;
            bus_addr  <= mem_addr;
            bus_wdata <= mem_wdata;
            bus_size  <= mem_size;
            uns_q     <= mem_unsigned;
          end
        end
        REQ: begin
          if (bus_gnt) begin
            state   <= WAIT;
            bus_req <= 1'b0;
            cnt     <= '0;
          end
        end
        WAIT: begin
          // A response in the last allowed cycle beats the timeout.
          if (bus_rvalid) begin
            state     <= DONE;
            mem_fault <= bus_err;
            mem_rdata <= ext;
          end else if (cnt == TO_LAST) begin
            state     <= DONE;
            mem_fault <= 1'b1;
            mem_rdata <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DONE: begin
          if (wb_wr_en) state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stall.sv
// Randomized self-checking bench for mem_access_stall.
// Acts as bus responder against a transaction-level model.
module tb_mem_access_stall;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_valid;
  logic        mem_is_load;
  logic        mem_is_store;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [1:0]  mem_size;
  logic        mem_unsigned;
  logic        wb_wr_en;
  logic        bus_req;
  logic        bus_we;
  logic [63:0] bus_addr;
  logic [63:0] bus_wdata;
  logic [1:0]  bus_size;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [63:0] bus_rdata;
  logic        bus_err;
  logic        mem_stall;
  logic [63:0] mem_rdata;
  logic        mem_fault;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_access_stall #(.TIMEOUT(TO)) dut (
    .clk(clk),
    .reset(reset),
    .mem_valid(mem_valid),
    .mem_is_load(mem_is_load),
    .mem_is_store(mem_is_store),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_size(mem_size),
    .mem_unsigned(mem_unsigned),
    .wb_wr_en(wb_wr_en),
    .bus_req(bus_req),
    .bus_we(bus_we),
    .bus_addr(bus_addr),
    .bus_wdata(bus_wdata),
    .bus_size(bus_size),
    .bus_gnt(bus_gnt),
    .bus_rvalid(bus_rvalid),
    .bus_rdata(bus_rdata),
    .bus_err(bus_err),
    .mem_stall(mem_stall),
    .mem_rdata(mem_rdata),
    .mem_fault(mem_fault)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ext_model(
      input logic [63:0] d,
      input logic [1:0]  sz,
      input logic        uns);
    logic [63:0] m;
    logic [63:0] v;
    int bits;
    if (sz == 2'd3) return d;
    bits = 8 * (1 << sz);
    m = 64'd1 << bits;
    v = d % m;
    if (!uns && v >= (m >> 1)) v = v - m;
    return v;
  endfunction

  function automatic logic [63:0] rnd64();
    return {32'($urandom), 32'($urandom)};
  endfunction

  task automatic run_acc(
      input logic        ld,
      input logic        st,
      input logic [63:0] addr,
      input logic [63:0] wdata,
      input logic [1:0]  sz,
      input logic        uns,
      input int          g,
      input int          rv,
      input logic [63:0] rdata,
      input logic        err,
      input logic        drop,
      input int          hold);
    logic        mis;
    logic        ex_fault;
    logic [63:0] ex_rdata;
    logic        ex_req;
    int          done_k;
    int          wt;
    mis = (addr % (64'd1 << sz)) != 0;
    wt = (rv + 1 < TO) ? rv + 1 : TO;
    done_k = mis ? 1 : 2 + g + wt;
    if (mis) begin
      ex_fault = 1'b1;
      ex_rdata = '0;
    end else if (rv < TO) begin
      ex_fault = err;
      ex_rdata = st ? 64'd0 : ext_model(rdata, sz, uns);
    end else begin
      ex_fault = 1'b1;
      ex_rdata = '0;
    end
    for (int k = 0; k < done_k; k++) begin
      @(negedge clk);
      if (k == 0) begin
        mem_valid    = 1'b1;
        mem_is_load  = ld;
        mem_is_store = st;
        mem_addr     = addr;
        mem_wdata    = wdata;
        mem_size     = sz;
        mem_unsigned = uns;
        wb_wr_en     = 1'b0;
      end else if (drop) begin
        mem_valid = 1'b0;
        mem_addr  = rnd64();
        mem_size  = 2'($urandom);
      end
      ex_req = !mis && k >= 1 && k <= g + 1;
      if (ex_req) bus_gnt = (k == g + 1);
      else bus_gnt = 1'($urandom);
      bus_err = 1'($urandom);
      bus_rdata = rnd64();
      if (!mis && k >= g + 2) begin
        bus_rvalid = (k - g - 2 == rv);
        if (bus_rvalid) begin
          bus_rdata = rdata;
          bus_err   = err;
        end
      end else begin
        bus_rvalid = 1'($urandom);
      end
      #1;
      chk("stall_busy", mem_stall, 1);
      chk("bus_req", bus_req, ex_req);
      if (ex_req) begin
        chk("bus_addr", bus_addr, addr);
        chk("bus_wdata", bus_wdata, wdata);
        chk("bus_size", bus_size, sz);
        chk("bus_we", bus_we, st);
      end
    end
    for (int h = 0; h <= hold; h++) begin
      @(negedge clk);
      wb_wr_en   = (h == hold);
      bus_gnt    = 1'($urandom);
      bus_rvalid = 1'($urandom);
      bus_err    = 1'($urandom);
      bus_rdata  = rnd64();
      #1;
      chk("stall_done", mem_stall, 0);
      chk("req_done", bus_req, 0);
      chk("fault", mem_fault, ex_fault);
      chk("rdata", mem_rdata, ex_rdata);
    end
    @(negedge clk);
    mem_valid  = 1'b0;
    wb_wr_en   = 1'b0;
    bus_gnt    = 1'($urandom);
    bus_rvalid = 1'($urandom);
    #1;
    chk("stall_idle", mem_stall, 0);
    chk("req_idle", bus_req, 0);
  endtask

  task automatic reset_mid(input logic in_req);
    @(negedge clk);
    mem_valid    = 1'b1;
    mem_is_load  = 1'b1;
    mem_is_store = 1'b0;
    mem_addr     = 64'h3000;
    mem_size     = 2'd3;
    bus_gnt      = 1'b0;
    bus_rvalid   = 1'b0;
    @(negedge clk);
    bus_gnt = !in_req;
    if (!in_req) begin
      @(negedge clk);
      bus_gnt = 1'b0;
    end
    #1;
    chk("rst_pre_stall", mem_stall, 1);
    chk("rst_pre_req", bus_req, in_req);
    reset = 1'b1;
    #1;
    chk("rst_req", bus_req, 0);
    chk("rst_stall", mem_stall, 0);
    chk("rst_addr", bus_addr, 0);
    @(negedge clk);
    reset      = 1'b0;
    mem_valid  = 1'b0;
    bus_rvalid = 1'b1;
    bus_gnt    = 1'b1;
    bus_err    = 1'b1;
    bus_rdata  = rnd64();
    #1;
    chk("post_rst_stall", mem_stall, 0);
    @(negedge clk);
    bus_rvalid = 1'b0;
    bus_gnt    = 1'b0;
    bus_err    = 1'b0;
    #1;
    chk("stale_req", bus_req, 0);
    chk("stale_fault", mem_fault, 0);
    chk("stale_rdata", mem_rdata, 0);
  endtask

  initial begin
    logic        ld;
    logic        st;
    logic [63:0] a;
    logic [1:0]  sz;
    reset        = 1'b1;
    mem_valid    = 1'b1;
    mem_is_load  = 1'b1;
    mem_is_store = 1'b1;
    mem_addr     = 64'h40;
    mem_wdata    = 64'h1234;
    mem_size     = 2'd3;
    mem_unsigned = 1'b0;
    wb_wr_en     = 1'b0;
    bus_gnt      = 1'b1;
    bus_rvalid   = 1'b1;
    bus_rdata    = '1;
    bus_err      = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_stall0", mem_stall, 0);
    chk("rst_req0", bus_req, 0);
    chk("rst_we0", bus_we, 0);
    chk("rst_addr0", bus_addr, 0);
    chk("rst_wdata0", bus_wdata, 0);
    chk("rst_size0", bus_size, 0);
    chk("rst_rdata0", mem_rdata, 0);
    chk("rst_fault0", mem_fault, 0);
    @(negedge clk);
    reset      = 1'b0;
    mem_valid  = 1'b0;
    bus_gnt    = 1'b0;
    bus_rvalid = 1'b0;

    run_acc(1, 0, 64'h1000, 64'h0, 2'd0, 0,
            0, 0, 64'h80, 0, 0, 0);
    run_acc(0, 1, 64'h2008, 64'hDEADBEEF, 2'd3, 0,
            4, 0, 64'h55, 0, 0, 0);
    run_acc(1, 0, 64'h1002, 64'h0, 2'd2, 0,
            0, 0, 64'h0, 0, 0, 1);
    run_acc(1, 0, 64'h1000, 64'h0, 2'd2, 1,
            1, 4, 64'hFFFF_FFFF, 0, 0, 0);
    run_acc(1, 0, 64'h1004, 64'h0, 2'd2, 0,
            0, 3, 64'h8000_0001, 0, 0, 0);
    run_acc(1, 0, 64'h1006, 64'h0, 2'd1, 1,
            0, 1, 64'hABCD_8765, 0, 0, 3);
    run_acc(1, 1, 64'h1008, 64'h77, 2'd3, 0,
            2, 2, rnd64(), 1, 1, 0);
    reset_mid(1'b0);
    run_acc(1, 0, 64'h10, 64'h0, 2'd0, 1,
            0, 0, 64'hF3, 0, 0, 0);
    reset_mid(1'b1);

    for (int i = 0; i < 150; i++) begin
      ld = 1'($urandom);
      st = 1'($urandom);
      sz = 2'($urandom);
      a  = rnd64();
      if ($urandom_range(3) != 0) a = a & ~64'h7;
      if (!ld && !st) begin
        @(negedge clk);
        mem_valid    = 1'b1;
        mem_is_load  = 1'b0;
        mem_is_store = 1'b0;
        mem_addr     = a;
        bus_gnt      = 1'($urandom);
        bus_rvalid   = 1'($urandom);
        #1;
        chk("noacc_stall", mem_stall, 0);
        chk("noacc_req", bus_req, 0);
      end else begin
        run_acc(ld, st, a, rnd64(), sz, 1'($urandom),
                $urandom_range(5), $urandom_range(5),
                rnd64(), 1'($urandom),
                1'($urandom), $urandom_range(2));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
